vga_computer_onchip_dpram: RTL

- Parametrised dual-port on-chip RAM, the next generation of the computer system's single-port on-chip memory.
- Two independent Avalon-MM slaves: s1 for the CPU and s2 for the pixel/DMA side.
- Adds configurable width, depth and read latency, readdatavalid/waitrequest handshakes, a defined collision policy and an optional post-reset clear engine.
- Sits between the system interconnect and the VGA frame/command buffers.

---
 rtl/vga_onchip_mem_pkg.sv | 26 ++
 rtl/vga_onchip_mem_rdpipe.sv | 51 +++++
 rtl/vga_computer_onchip_dpram.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vga_onchip_mem_pkg.sv
// Shared types and helpers for the dual-port on-chip frame/command memory.
package vga_onchip_mem_pkg;

    // Controller states: IDLE while in reset, CLEAR during the optional sweep, READY for traffic
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Width of one byte lane; the lane count of a port is DATA_W / LANE_W
    localparam int LANE_W = 8;

    // True when a word address lands inside the populated part of the array
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

    // Byte-lane merge used both for writes and for write-first read bypass
    function automatic logic [LANE_W-1:0] lane_merge(input logic [LANE_W-1:0] old_lane,
                                                     input logic [LANE_W-1:0] new_lane,
                                                     input logic              sel);
        return sel ? new_lane : old_lane;
    endfunction

endpackage

// File: rtl/vga_onchip_mem_rdpipe.sv
// Per-port read valid/data pipeline. The RAM output register supplies the first
// cycle of latency; LATENCY=2 adds an output register. All stages hold while en is low.
module vga_onchip_mem_rdpipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    logic v1_reg;

    // Stage 1 valid: tracks the RAM output register, flushed by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg <= 1'b0;
        end else if (en) begin
            v1_reg <= req;
        end
    end

    generate
        if (LATENCY >= 2) begin : g_reg_q
            logic              v2_reg;
            logic [DATA_W-1:0] d2_reg;

            // Registered output stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2_reg <= 1'b0;
                    d2_reg <= '0;
                end else if (en) begin
                    v2_reg <= v1_reg;
                    d2_reg <= v1_reg ? ram_q : '0;
                end
            end

            assign readdatavalid = v2_reg & en;
            assign readdata      = d2_reg;
        end else begin : g_unreg_q
            assign readdatavalid = v1_reg & en;
            assign readdata      = v1_reg ? ram_q : '0;
        end
    endgenerate

endmodule

// File: rtl/vga_computer_onchip_dpram.sv
// Dual-port on-chip RAM with two Avalon-MM slaves (s1 = CPU, s2 = pixel/DMA).
// s1 wins write/write collisions; write/read collisions are write-first.
// Define ONCHIP_MEM_CLEAR_EN to zero the array after every reset.
module vga_computer_onchip_dpram
    import vga_onchip_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 15,
    parameter int DEPTH        = 25000,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 reset_req,
    input  logic [ADDR_W-1:0]    s1_address,
    input  logic                 s1_chipselect,
    input  logic                 s1_read,
    input  logic                 s1_write,
    input  logic [DATA_W/8-1:0]  s1_byteenable,
    input  logic [DATA_W-1:0]    s1_writedata,
    output logic [DATA_W-1:0]    s1_readdata,
    output logic                 s1_readdatavalid,
    output logic                 s1_waitrequest,
    input  logic [ADDR_W-1:0]    s2_address,
    input  logic                 s2_chipselect,
    input  logic                 s2_read,
    input  logic                 s2_write,
    input  logic [DATA_W/8-1:0]  s2_byteenable,
    input  logic [DATA_W-1:0]    s2_writedata,
    output logic [DATA_W-1:0]    s2_readdata,
    output logic                 s2_readdatavalid,
    output logic                 s2_waitrequest,
    output logic                 clear_busy
);

    localparam int LANES = DATA_W / LANE_W;

    state_t state_reg, state_next;
    logic   clocken, waitreq, clear_last;

    assign clocken = clken & ~reset_req;

    // Command acceptance; read+write together counts as a write only
    logic s1_acc, s1_rd, s1_we, s1_in_range;
    logic s2_acc, s2_rd, s2_we, s2_in_range;
    logic same_addr;

    assign s1_acc      = s1_chipselect & (s1_read | s1_write) & ~waitreq & clocken;
    assign s2_acc      = s2_chipselect & (s2_read | s2_write) & ~waitreq & clocken;
    assign s1_in_range = addr_in_range(32'(s1_address), DEPTH);
    assign s2_in_range = addr_in_range(32'(s2_address), DEPTH);
    assign same_addr   = (s1_address == s2_address);
    assign s1_rd       = s1_acc & s1_read & ~s1_write;
    assign s2_rd       = s2_acc & s2_read & ~s2_write;
    assign s1_we       = s1_acc & s1_write & s1_in_range;
    // s2 loses the whole word when s1 writes the same address
    assign s2_we       = s2_acc & s2_write & s2_in_range & ~(s1_we & same_addr);

`ifdef ONCHIP_MEM_CLEAR_EN
    logic [ADDR_W-1:0] clear_addr_reg;
    logic              clear_we;

    assign clear_we   = clocken & (state_reg == ST_CLEAR);
    assign clear_last = (clear_addr_reg == ADDR_W'(DEPTH - 1));

    // Sweep counter; restarts from 0 whenever the sweep is not running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_addr_reg <= '0;
        end else if (clocken) begin
            if (state_reg == ST_CLEAR) begin
                clear_addr_reg <= clear_addr_reg + 1'b1;
            end else begin
                clear_addr_reg <= '0;
            end
        end
    end
`else
    assign clear_last = 1'b1;
`endif

    // State register; advances only on enabled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else if (clocken) begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
`ifdef ONCHIP_MEM_CLEAR_EN
            ST_IDLE:  state_next = ST_CLEAR;
`else
            ST_IDLE:  state_next = ST_READY;
`endif
            ST_CLEAR: if (clear_last) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        waitreq = (state_reg != ST_READY);
`ifdef ONCHIP_MEM_CLEAR_EN
        clear_busy = (state_reg == ST_CLEAR);
`else
        clear_busy = 1'b0;
`endif
    end

    assign s1_waitrequest = waitreq;
    assign s2_waitrequest = waitreq;

    // Storage plus per-port registered read; the bypass fields capture a
    // same-cycle write from the other port so the read can be made write-first
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  q1_reg, q2_reg, byp1_data_reg, byp2_data_reg;
    logic [LANES-1:0]   byp1_be_reg, byp2_be_reg;
    logic               byp1_reg, byp2_reg, rng1_reg, rng2_reg;

    // Array writes (s1 written last so it wins) and registered reads
    always_ff @(posedge clk) begin
`ifdef ONCHIP_MEM_CLEAR_EN
        if (clear_we) begin
            mem[clear_addr_reg] <= '0;
        end
`endif
        for (int li = 0; li < LANES; li++) begin
            if (s2_we && s2_byteenable[li]) begin
                mem[s2_address][li*LANE_W +: LANE_W] <= s2_writedata[li*LANE_W +: LANE_W];
            end
            if (s1_we && s1_byteenable[li]) begin
                mem[s1_address][li*LANE_W +: LANE_W] <= s1_writedata[li*LANE_W +: LANE_W];
            end
        end
        if (s1_rd) begin
            q1_reg        <= mem[s1_address];
            rng1_reg      <= s1_in_range;
            byp1_reg      <= s2_we & same_addr;
            byp1_data_reg <= s2_writedata;
            byp1_be_reg   <= s2_byteenable;
        end
        if (s2_rd) begin
            q2_reg        <= mem[s2_address];
            rng2_reg      <= s2_in_range;
            byp2_reg      <= s1_we & same_addr;
            byp2_data_reg <= s1_writedata;
            byp2_be_reg   <= s1_byteenable;
        end
    end

    logic [DATA_W-1:0] q1_merged, q2_merged, q1_data, q2_data;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign q1_merged[gi*LANE_W +: LANE_W] = lane_merge(q1_reg[gi*LANE_W +: LANE_W],
                byp1_data_reg[gi*LANE_W +: LANE_W], byp1_reg & byp1_be_reg[gi]);
            assign q2_merged[gi*LANE_W +: LANE_W] = lane_merge(q2_reg[gi*LANE_W +: LANE_W],
                byp2_data_reg[gi*LANE_W +: LANE_W], byp2_reg & byp2_be_reg[gi]);
        end
    endgenerate

    // Out-of-range reads return zero but still produce a valid pulse
    assign q1_data = rng1_reg ? q1_merged : '0;
    assign q2_data = rng2_reg ? q2_merged : '0;

    vga_onchip_mem_rdpipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rdpipe_s1 (
        .clk           (clk),
        .rst           (reset),
        .en            (clocken),
        .req           (s1_rd),
        .ram_q         (q1_data),
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    vga_onchip_mem_rdpipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rdpipe_s2 (
        .clk           (clk),
        .rst           (reset),
        .en            (clocken),
        .req           (s2_rd),
        .ram_q         (q2_data),
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

endmodule
